// File: rtl/rom_reload_pkg.sv
// Shared types and constants for the ROM reload writer: FSM states, word geometry
// and the width of the written-word counter.
package rom_reload_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_SHIFT = $clog2(WORD_BYTES);
    localparam int WORDS_W    = 17;
    localparam int ENTRY_W    = 64;

endpackage

// File: rtl/rom_reload_fifo.sv
// Synchronous FIFO with show-ahead output: rdata always shows the oldest entry,
// and a pop in the same cycle as a push makes room for it.
module rom_reload_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: rdata is only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/rom_reload_writer.sv
// Buffers word writes from the UART ROM loader and replays them to a byte-addressed
// memory write port, holding the CPU in reset until the load has fully landed.
module rom_reload_writer
    import rom_reload_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int ADDR_W        = 18,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_active,
    input  logic               in_wr,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_data,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ack,
    output logic               cpu_hold,
    output logic               reload_done,
    output logic               overflow,
    output logic               range_err,
    output logic [WORDS_W-1:0] words_written,
    output state_t             fsm_state
);
    localparam int IDX_W = ADDR_W - BYTE_SHIFT;
    localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic                active_q;
    logic                rise;
    logic                fall;
    logic                load_start;
    logic                wr_valid;
    logic                in_range;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [ENTRY_W-1:0]  head;
    logic [SC_W-1:0]     quiet_cnt;
    logic                settled;
    logic                addr_hi_unused;

    assign rise     = in_active & ~active_q;
    assign fall     = ~in_active & active_q;
    assign wr_valid = in_wr & in_active;
    assign in_range = (in_addr >> IDX_W) == '0;

    // mem_req/mem_ack: mem_req stays high with mem_addr/mem_wdata stable until a
    // cycle where mem_ack is also high; that cycle completes the transfer and the
    // next entry (if any) is presented immediately. mem_ack alone does nothing.
    assign pop  = mem_req & mem_ack;
    assign push = wr_valid & in_range & (~full | pop);

    rom_reload_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_data, in_addr}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign mem_req        = ~empty;
    assign mem_addr       = mem_req ? {head[IDX_W-1:0], {BYTE_SHIFT{1'b0}}} : '0;
    assign mem_wdata      = mem_req ? head[63:32] : '0;
    assign addr_hi_unused = |head[31:IDX_W];

    assign settled   = (quiet_cnt == SETTLE_LAST);
    assign cpu_hold  = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            active_q <= 1'b0;
        end else begin
            state    <= state_next;
            active_q <= in_active;
        end
    end

    always_comb begin
        state_next  = state;
        load_start  = 1'b0;
        reload_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_next = LOAD;
                    load_start = 1'b1;
                end
            end
            LOAD: begin
                if (fall) state_next = DRAIN;
            end
            DRAIN: begin
                if (rise)       state_next = LOAD;
                else if (empty) state_next = SETTLE;
            end
            SETTLE: begin
                if (rise) begin
                    state_next = LOAD;
                end else if (settled) begin
                    state_next  = IDLE;
                    reload_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts quiet cycles since the last completed write (or load start), saturating
    // at the settle length, so SETTLE releases SETTLE_CYCLES after the last ack.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            quiet_cnt <= '0;
        end else if (load_start || pop) begin
            quiet_cnt <= '0;
        end else if (!settled) begin
            quiet_cnt <= quiet_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            words_written <= '0;
            overflow      <= 1'b0;
            range_err     <= 1'b0;
        end else begin
            if (load_start) begin
                words_written <= '0;
                overflow      <= 1'b0;
                range_err     <= 1'b0;
            end else if (pop && (words_written != '1)) begin
                words_written <= words_written + 1'b1;
            end
            // A drop in the load-start cycle still leaves its flag set.
            if (wr_valid && !in_range)               range_err <= 1'b1;
            if (wr_valid && in_range && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_reload_writer.sv
// Randomized and directed bench for rom_reload_writer, checked against a queue-based
// reference model of the write buffer and the settle/release timing rules.
module tb_rom_reload_writer;
    import rom_reload_pkg::*;

    localparam int FIFO_DEPTH    = 8;
    localparam int ADDR_W        = 18;
    localparam int SETTLE_CYCLES = 16;
    localparam int IDX_LIMIT     = 1 << (ADDR_W - 2);

    logic        clk       = 1'b0;
    logic        nrst      = 1'b0;
    logic        in_active = 1'b0;
    logic        in_wr     = 1'b0;
    logic [31:0] in_addr   = '0;
    logic [31:0] in_data   = '0;
    logic        mem_ack   = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              reload_done;
    logic              overflow;
    logic              range_err;
    logic [16:0]       words_written;
    state_t            fsm_state;

    rom_reload_writer #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .ADDR_W        (ADDR_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .in_active     (in_active),
        .in_wr         (in_wr),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .cpu_hold      (cpu_hold),
        .reload_done   (reload_done),
        .overflow      (overflow),
        .range_err     (range_err),
        .words_written (words_written),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [63:0] exp_q[$];
    logic [16:0] m_acks     = '0;
    logic        m_ovf      = 1'b0;
    logic        m_rng      = 1'b0;
    int          m_last_ack = 0;
    int          load_id    = 0;
    int          seen_id    = 0;
    logic        m_popped;
    logic [63:0] m_dummy;
    logic        mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Each clock: the oldest buffered word completes if acked, then a strobed word
    // is kept if in range and there is room (after that completion), else flagged.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_q.delete();
            m_acks  = '0;
            m_ovf   = 1'b0;
            m_rng   = 1'b0;
            seen_id = load_id;
        end else begin
            m_popped = (exp_q.size() != 0) && mem_ack;
            if (seen_id != load_id) begin
                seen_id    = load_id;
                m_acks     = '0;
                m_ovf      = 1'b0;
                m_rng      = 1'b0;
                m_last_ack = cyc;
            end
            if (m_popped) begin
                m_dummy = exp_q.pop_front();
                if (m_acks != 17'h1FFFF) m_acks = m_acks + 17'd1;
                m_last_ack = cyc;
            end
            if (in_wr && in_active) begin
                if (in_addr >= IDX_LIMIT)             m_rng = 1'b1;
                else if (exp_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
                else                                  exp_q.push_back({in_data, in_addr});
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mem_req", mem_req, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("mem_addr", mem_addr, 64'(exp_q[0][31:0]) * WORD_BYTES);
                check("mem_wdata", mem_wdata, exp_q[0][63:32]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        in_wr   = 1'b1;
        in_addr = a;
        in_data = d;
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic load_begin(input bit restart);
        if (!restart) load_id++;
        in_active = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_load(output int done_cyc);
        int f;
        int exp_done;
        bit seen;
        in_active = 1'b0;
        in_wr     = 1'b0;
        mem_ack   = 1'b1;
        f         = cyc;
        seen      = 1'b0;
        done_cyc  = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (reload_done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end else begin
                check("hold_settle", cpu_hold, 1);
            end
        end
        check("done_seen", seen, 1);
        if (seen) begin
            exp_done = (f + 2 > m_last_ack + SETTLE_CYCLES) ? f + 2 : m_last_ack + SETTLE_CYCLES;
            check("done_cycle", done_cyc, exp_done);
            check("hold_at_done", cpu_hold, 1);
            check("words", words_written, m_acks);
            check("overflow", overflow, m_ovf);
            check("range_err", range_err, m_rng);
            @(negedge clk);
            check("hold_release", cpu_hold, 0);
            check("done_pulse", reload_done, 0);
            check("state_idle", fsm_state, IDLE);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int d;

        repeat (3) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", reload_done, 0);
        check("rst_words", words_written, 0);
        check("rst_flags", {overflow, range_err}, 0);
        check("rst_state", fsm_state, IDLE);
        nrst   = 1'b1;
        mon_en = 1'b1;

        // reset in the middle of a pending request
        mem_ack = 1'b0;
        load_begin(0);
        write_word(32'd5, 32'h1234_5678);
        write_word(32'd6, 32'h9ABC_DEF0);
        check("rstmid_req_before", mem_req, 1);
        @(posedge clk);
        #2;
        nrst      = 1'b0;
        in_active = 1'b0;
        #1;
        check("rstmid_req", mem_req, 0);
        check("rstmid_hold", cpu_hold, 0);
        check("rstmid_words", words_written, 0);
        check("rstmid_state", fsm_state, IDLE);
        @(negedge clk);
        nrst = 1'b1;

        // basic load, ack always high
        mem_ack = 1'b1;
        check("hold_pre", cpu_hold, 0);
        load_begin(0);
        check("hold_rise", cpu_hold, 1);
        check("state_load", fsm_state, LOAD);
        for (int i = 0; i < 4; i++) write_word(32'(i), 32'hA0 + 32'(i));
        finish_load(d);
        check("basic_done_after_ack", d - m_last_ack, SETTLE_CYCLES);
        check("basic_words", words_written, 4);

        // back-pressure: 10 writes into 8 slots while ack is held low
        mem_ack = 1'b0;
        load_begin(0);
        for (int i = 0; i < 10; i++) write_word(32'd100 + 32'(i), $urandom);
        repeat (10) @(negedge clk);
        check("bp_overflow", overflow, 1);
        check("bp_words_stalled", words_written, 0);
        mem_ack = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_drained", mem_req, 0);
        check("bp_words", words_written, 8);
        finish_load(d);

        // full FIFO with a write in the same cycle as an ack
        mem_ack = 1'b0;
        load_begin(0);
        for (int i = 0; i < FIFO_DEPTH; i++) write_word(32'd200 + 32'(i), $urandom);
        check("fp_full_req", mem_req, 1);
        mem_ack = 1'b1;
        write_word(32'd300, 32'hF00D_F00D);
        repeat (12) @(negedge clk);
        check("fp_overflow", overflow, 0);
        check("fp_words", words_written, FIFO_DEPTH + 1);
        finish_load(d);

        // out-of-range index, then highest legal index
        mem_ack = 1'b1;
        load_begin(0);
        write_word(32'h0001_0000, 32'h0BAD_0BAD);
        check("rng_req", mem_req, 0);
        check("rng_err", range_err, 1);
        write_word(32'h0000_FFFF, 32'h600D_600D);
        repeat (3) @(negedge clk);
        finish_load(d);
        check("rng_sticky_idle", range_err, 1);
        load_begin(0);
        check("rng_cleared", range_err, 0);
        write_word(32'd7, $urandom);
        finish_load(d);

        // in_active re-rises during SETTLE
        mem_ack = 1'b1;
        load_begin(0);
        for (int i = 0; i < 3; i++) write_word(32'd40 + 32'(i), $urandom);
        in_active = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rs_hold", cpu_hold, 1);
            check("rs_no_done", reload_done, 0);
        end
        check("rs_state_settle", fsm_state, SETTLE);
        load_begin(1);
        check("rs_hold_reload", cpu_hold, 1);
        check("rs_state_load", fsm_state, LOAD);
        check("rs_words_kept", words_written, 3);
        for (int i = 0; i < 2; i++) write_word(32'd50 + 32'(i), $urandom);
        finish_load(d);
        check("rs_words", words_written, 5);

        // randomized loads with varying ack density
        for (int l = 0; l < 6; l++) begin
            mem_ack = 1'($urandom_range(0, 1));
            load_begin(0);
            for (int c = 0; c < 60; c++) begin
                mem_ack = (l % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                in_wr   = ($urandom_range(0, 2) == 0);
                in_addr = ($urandom_range(0, 9) == 0) ? 32'h0001_0000 + $urandom_range(0, 1000)
                                                      : $urandom_range(0, IDX_LIMIT - 1);
                in_data = $urandom;
                @(negedge clk);
            end
            in_wr = 1'b0;
            finish_load(d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
